// File: rtl/geo_cmd_arbiter.sv
// Round-robin arbiter that lets the geometry engine (A) and the host bridge (B)
// share the pixel-writer command input. It supports burst limiting, ownership lock, and a stall counter.
module geo_cmd_arbiter #(
    parameter int CMD_BITS  = 40,
    parameter int BURST_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [CMD_BITS-1:0] a_cmd,
    input  logic                a_lock,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [CMD_BITS-1:0] b_cmd,
    input  logic                b_lock,
    output logic                b_ready,
    input  logic                draw_busy,
    output logic                cmd_rdy,
    output logic [CMD_BITS-1:0] cmd_out,
    output logic [1:0]          owner,
    output logic [7:0]          stall_cnt,
    input  logic                stall_rst
);

    // state | meaning
    // IDLE  | no owner, selection made directly from the incoming valids
    // OWN_A | port A owns the writer until it idles unlocked or its burst expires
    // OWN_B | port B owns the writer, same rules mirrored
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    state_t              state_q, state_d;
    logic [7:0]          burst_cnt_q, burst_cnt_d;
    logic                last_b_q, last_b_d;
    logic                cmd_rdy_q, cmd_rdy_d;
    logic [CMD_BITS-1:0] cmd_out_q, cmd_out_d;
    logic [7:0]          stall_cnt_q, stall_cnt_d;

    logic                sel_a, sel_b;
    logic                acc_a, acc_b, acc;
    logic [7:0]          burst_nxt;

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        case (state_q)
            OWN_A: sel_a = 1'b1;
            OWN_B: sel_b = 1'b1;
            default: begin
                // A tie goes to whichever port was not served last.
                if (a_valid && b_valid) begin
                    sel_a = last_b_q;
                    sel_b = !last_b_q;
                end else begin
                    sel_a = a_valid;
                    sel_b = b_valid;
                end
            end
        endcase
    end

    assign acc_a   = sel_a && a_valid && !draw_busy && !reset;
    assign acc_b   = sel_b && b_valid && !draw_busy && !reset;
    assign acc     = acc_a || acc_b;
    assign a_ready = acc_a;
    assign b_ready = acc_b;

    assign burst_nxt = (acc && burst_cnt_q != BURST_LIM) ? burst_cnt_q + 8'd1 : burst_cnt_q;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_nxt;
        last_b_d    = last_b_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = {7'd0, acc};
                if (sel_a) begin
                    state_d = OWN_A;
                end else if (sel_b) begin
                    state_d = OWN_B;
                end
                // With a one-command burst, the entry accept already uses up the turn.
                if (BURST_LIM == 8'd1 && acc_a && b_valid && !a_lock) begin
                    state_d     = OWN_B;
                    burst_cnt_d = '0;
                    last_b_d    = 1'b0;
                end
                if (BURST_LIM == 8'd1 && acc_b && a_valid && !b_lock) begin
                    state_d     = OWN_A;
                    burst_cnt_d = '0;
                    last_b_d    = 1'b1;
                end
            end
            OWN_A: begin
                if (!a_valid && !a_lock) begin
                    state_d = b_valid ? OWN_B : IDLE;
                end else if (burst_nxt == BURST_LIM && b_valid && !a_lock) begin
                    state_d = OWN_B;
                end
            end
            OWN_B: begin
                if (!b_valid && !b_lock) begin
                    state_d = a_valid ? OWN_A : IDLE;
                end else if (burst_nxt == BURST_LIM && a_valid && !b_lock) begin
                    state_d = OWN_A;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && state_d != state_q) begin
            burst_cnt_d = '0;
            last_b_d    = (state_q == OWN_B);
        end
    end

    always_comb begin
        cmd_rdy_d = acc;
        cmd_out_d = cmd_out_q;
        if (acc_a) begin
            cmd_out_d = a_cmd;
        end else if (acc_b) begin
            cmd_out_d = b_cmd;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_rst) begin
            stall_cnt_d = '0;
        end else if ((a_valid || b_valid) && draw_busy && stall_cnt_q != 8'hFF) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            last_b_q    <= 1'b1;
            cmd_rdy_q   <= 1'b0;
            cmd_out_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_b_q    <= last_b_d;
            cmd_rdy_q   <= cmd_rdy_d;
            cmd_out_q   <= cmd_out_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cmd_rdy   = cmd_rdy_q;
    assign cmd_out   = cmd_out_q;
    assign owner     = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_geo_cmd_arbiter.sv
// Bench for geo_cmd_arbiter: directed scenarios plus random traffic, checked
// against a port-level reference model and an output scoreboard.
module tb_geo_cmd_arbiter;

    localparam int BMAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, a_lock = 1'b0, a_ready;
    logic [39:0] a_cmd = '0;
    logic        b_valid = 1'b0, b_lock = 1'b0, b_ready;
    logic [39:0] b_cmd = '0;
    logic        draw_busy = 1'b0, stall_rst = 1'b0;
    logic        cmd_rdy;
    logic [39:0] cmd_out;
    logic [1:0]  owner;
    logic [7:0]  stall_cnt;

    geo_cmd_arbiter #(.CMD_BITS(40), .BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_cmd(a_cmd), .a_lock(a_lock), .a_ready(a_ready),
        .b_valid(b_valid), .b_cmd(b_cmd), .b_lock(b_lock), .b_ready(b_ready),
        .draw_busy(draw_busy), .cmd_rdy(cmd_rdy), .cmd_out(cmd_out),
        .owner(owner), .stall_cnt(stall_cnt), .stall_rst(stall_rst)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    bit          started = 1'b0;
    bit          acc_a = 1'b0, acc_b = 1'b0;
    int          seq_a = 0, seq_b = 0;
    string       glog = "";
    string       rlog = "";
    logic [39:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_assert++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string want);
        n_assert++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %s expected %s", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commands carry the port number in the target field and a per-port sequence in addr.
    task automatic new_cmd(input int p, output logic [39:0] c);
        logic [19:0] s;
        if (p == 1) begin
            seq_a++;
            s = 20'(seq_a);
        end else begin
            seq_b++;
            s = 20'(seq_b);
        end
        c = {4'($urandom_range(0, 15)), 8'($urandom), 4'($urandom_range(0, 15)), 4'(p), s};
    endtask

    task automatic advance();
        tick();
        if (acc_a) new_cmd(1, a_cmd);
        if (acc_b) new_cmd(2, b_cmd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        draw_busy = 1'b0; stall_rst = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model: owner 0 none / 1 A / 2 B, burst count of the current owner,
    // last owner served, and the registered output it should be presenting.
    int          m_owner = 0, m_count = 0, m_last = 2, m_stall = 0;
    bit          m_pend = 1'b0;
    logic [39:0] m_out = '0;

    always @(negedge clk) begin
        bit v[0:2];
        bit l[0:2];
        int sel, o, nxt, cnt;
        bit g;
        if (started) begin
            v[0] = 1'b0; l[0] = 1'b0;
            v[1] = a_valid; v[2] = b_valid;
            l[1] = a_lock;  l[2] = b_lock;
            check("owner", 64'(owner), 64'(m_owner));
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            check("cmd_rdy", 64'(cmd_rdy), 64'(m_pend));
            if (!m_pend) check("cmd_out_hold", 64'(cmd_out), 64'(m_out));

            if (m_owner != 0) sel = m_owner;
            else if (v[1] && v[2]) sel = 3 - m_last;
            else if (v[1]) sel = 1;
            else if (v[2]) sel = 2;
            else sel = 0;
            g = (sel != 0) && v[sel] && !draw_busy && !reset;
            check("a_ready", 64'(a_ready), 64'(g && sel == 1));
            check("b_ready", 64'(b_ready), 64'(g && sel == 2));

            if (a_ready) glog = {glog, "A"};
            else if (b_ready) glog = {glog, "B"};
            else glog = {glog, "-"};
            rlog = {rlog, cmd_rdy ? "1" : "0"};
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;

            if (g) exp_q.push_back(sel == 1 ? a_cmd : b_cmd);

            if (reset) begin
                m_owner = 0; m_count = 0; m_last = 2; m_stall = 0;
                m_pend = 1'b0; m_out = '0;
            end else begin
                m_pend = g;
                if (g) m_out = (sel == 1) ? a_cmd : b_cmd;
                if (stall_rst) m_stall = 0;
                else if ((v[1] || v[2]) && draw_busy) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
                if (m_owner == 0) begin
                    m_owner = sel;
                    m_count = g ? 1 : 0;
                end else begin
                    cnt = g ? ((m_count < BMAX) ? m_count + 1 : BMAX) : m_count;
                    o = 3 - m_owner;
                    nxt = m_owner;
                    if (!v[m_owner] && !l[m_owner]) nxt = v[o] ? o : 0;
                    else if (cnt == BMAX && v[o] && !l[m_owner]) nxt = o;
                    if (nxt != m_owner) begin
                        m_last = m_owner;
                        m_owner = nxt;
                        m_count = 0;
                    end else begin
                        m_count = cnt;
                    end
                end
            end
        end
    end

    // Output monitor: every cmd_rdy strobe must deliver the oldest accepted command.
    always @(negedge clk) begin
        logic [39:0] e;
        if (started && cmd_rdy) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL cmd_out: strobe with nothing accepted, got %0h expected none", cmd_out);
            end else begin
                e = exp_q.pop_front();
                check("cmd_out", 64'(cmd_out), 64'(e));
            end
        end
    end

    initial begin
        tick();
        started = 1'b1;
        tick();
        reset = 1'b0;

        // A alone, three commands back to back
        glog = ""; rlog = "";
        a_valid = 1'b1;
        a_cmd = 40'h1FF3000010; tick();
        a_cmd = 40'h1FF3000011; tick();
        a_cmd = 40'h1FF3000012; tick();
        a_valid = 1'b0;
        check("t1_owner", 64'(owner), 64'd1);
        check("t1_rdy", 64'(cmd_rdy), 64'd1);
        check("t1_out", 64'(cmd_out), 64'h1FF3000012);
        tick();
        check("t1_hold", 64'(cmd_out), 64'h1FF3000012);
        tick();
        check_str("t1_grants", glog, "AAA--");
        check_str("t1_rdy_seq", rlog, "01110");

        // Both continuously valid: bursts of four alternate with no gap
        do_reset();
        new_cmd(1, a_cmd); new_cmd(2, b_cmd);
        a_valid = 1'b1; b_valid = 1'b1;
        glog = "";
        repeat (12) advance();
        check_str("t2_burst", glog, "AAAABBBBAAAA");
        a_valid = 1'b0; b_valid = 1'b0;
        tick(); tick();

        // B locks across PXCOPY / PXPASTE while A waits
        do_reset();
        glog = "";
        b_valid = 1'b1; b_lock = 1'b1; b_cmd = 40'h6123200100;
        tick();
        b_valid = 1'b0; a_valid = 1'b1; new_cmd(1, a_cmd);
        tick();
        tick();
        b_valid = 1'b1; b_cmd = 40'h3123200200;
        tick();
        b_valid = 1'b0; b_lock = 1'b0;
        tick();
        tick();
        a_valid = 1'b0;
        check_str("t3_lock", glog, "B--B-A");
        tick(); tick();

        // Back-pressure and stall counter
        do_reset();
        glog = "";
        a_valid = 1'b1; new_cmd(1, a_cmd); draw_busy = 1'b1;
        repeat (5) tick();
        check("t4_stall5", 64'(stall_cnt), 64'd5);
        check("t4_rdy", 64'(cmd_rdy), 64'd0);
        check_str("t4_no_accept", glog, "-----");
        stall_rst = 1'b1;
        tick();
        stall_rst = 1'b0;
        check("t4_stall_rst", 64'(stall_cnt), 64'd0);
        repeat (300) tick();
        check("t4_stall_sat", 64'(stall_cnt), 64'd255);
        draw_busy = 1'b0;
        tick();
        a_valid = 1'b0;
        tick(); tick();

        // Reset the cycle after an accept
        do_reset();
        a_valid = 1'b1; new_cmd(1, a_cmd); draw_busy = 1'b1;
        tick();
        draw_busy = 1'b0;
        tick();
        check("t5_rdy_before", 64'(cmd_rdy), 64'd1);
        check("t5_stall_before", 64'(stall_cnt), 64'd1);
        a_valid = 1'b0; reset = 1'b1;
        tick();
        check("t5_rdy", 64'(cmd_rdy), 64'd0);
        check("t5_owner", 64'(owner), 64'd0);
        check("t5_stall", 64'(stall_cnt), 64'd0);
        reset = 1'b0;
        tick();

        // Random traffic; producers hold a command until it is accepted
        for (int i = 0; i < 10000; i++) begin
            if (acc_a || !a_valid) begin
                a_valid = ($urandom_range(0, 99) < 60);
                if (a_valid) new_cmd(1, a_cmd);
            end
            if (acc_b || !b_valid) begin
                b_valid = ($urandom_range(0, 99) < 60);
                if (b_valid) new_cmd(2, b_cmd);
            end
            a_lock = a_lock ? ($urandom_range(0, 99) >= 25) : ($urandom_range(0, 99) < 8);
            b_lock = b_lock ? ($urandom_range(0, 99) >= 25) : ($urandom_range(0, 99) < 8);
            draw_busy = ($urandom_range(0, 99) < 25);
            stall_rst = ($urandom_range(0, 99) < 3);
            tick();
        end

        a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        draw_busy = 1'b0; stall_rst = 1'b0;
        repeat (3) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/geo_cmd_arbiter.md
Name: geo_cmd_arbiter

Overview:
Two-port arbiter that shares the single 40-bit pixel-writer command input (cmd_rdy/cmd_in, draw_busy back-pressure) between two producers: port A (geometry engine) and port B (host/Z80 bridge direct pixel access). Arbitration is round-robin with a bounded burst length and a lock input, so multi-command sequences (e.g. PXCOPY then PXPASTE) are not interleaved. The output is registered and honours draw_busy. A saturating stall counter is provided for host diagnostics.

Parameters:
CMD_BITS, 40, command word width {cmd[39:36], colour[35:28], bpp[27:24], target[23:20], addr[19:0]}
BURST_MAX, 16, max consecutive unlocked accepts by one owner while the other port is requesting (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
a_valid  in  1  port A command present
a_cmd  in  CMD_BITS  port A command word
a_lock  in  1  port A requests to keep ownership
a_ready  out  1  port A command accepted this cycle
b_valid  in  1  port B command present
b_cmd  in  CMD_BITS  port B command word
b_lock  in  1  port B requests to keep ownership
b_ready  out  1  port B command accepted this cycle
draw_busy  in  1  pixel-writer FIFO full
cmd_rdy  out  1  one-cycle strobe: cmd_out valid, shift into FIFO
cmd_out  out  CMD_BITS  command word to pixel writer
owner  out  2  00 none, 01 A, 10 B
stall_cnt  out  8  saturating count of cycles with a request blocked by draw_busy
stall_rst  in  1  clear stall_cnt

Behaviour:
- Reset is clk, synchronous, active-high. Reset values: cmd_rdy=0, cmd_out=0, owner=00, stall_cnt=0, burst_cnt=0, last_served=B (A wins the first tie), state IDLE.
- Transfer rule: a port transfers when valid && ready. ready is combinational: a_ready = (sel==A) && a_valid && !draw_busy && !reset. b_ready is the same with B.
- Latency: 1 cycle. An accepted command appears on cmd_out with cmd_rdy=1 on the next clk. With no accept, cmd_rdy=0 and cmd_out holds its last value.
- Throughput: 1 command per cycle while draw_busy=0.
- draw_busy is sampled combinationally. At most one command can be in flight when draw_busy rises; the FIFO reserve word absorbs it.
- States:
  - IDLE: nothing owned.
    - Only A valid -> OWN_A. Only B valid -> OWN_B.
    - Both valid -> the port not equal to last_served.
    - sel is the incoming choice in the same cycle, so there is no dead cycle.
  - OWN_x:
    - sel=x. Each accept increments burst_cnt, saturating at BURST_MAX.
    - Leave when x_valid=0 and x_lock=0. Go to OWN_other if other is valid, else IDLE.
    - Also leave when burst_cnt==BURST_MAX && other_valid && !x_lock. Go to OWN_other.
    - A port-change transition in the same cycle as a transfer takes effect the following cycle.
    - x_lock=1 holds ownership even when x_valid=0 and the other port is valid. The lock is unbounded; the producer is responsible for releasing it.
  - On any ownership change: burst_cnt=0, last_served=previous owner.
- owner output reflects the registered state (IDLE=00).
- stall_cnt:
  - Increments when (a_valid||b_valid) && draw_busy, saturating at 255.
  - stall_rst takes priority over increment in the same cycle.
- The command word passes through unmodified. NOP (code 0) is forwarded like any other command.
- Reset mid-operation: a pending registered command is discarded (cmd_rdy=0 next cycle), ownership and lock are lost, and the producers must re-present.
- lock asserted by the non-owner has no effect until that port gains ownership.

Test Plan:
- Reset, then A alone sends 3 cmds 0x1_FF_3_0_00010..12 with draw_busy=0 -> cmd_rdy high 3 consecutive cycles, each 1 cycle after accept; cmd_out matches in order; owner=01.
- Both valid from IDLE after reset -> A served first. BURST_MAX=4, both continuously valid, unlocked -> grant sequence AAAABBBBAAAA; no idle cycle at switches.
- B asserts b_lock, sends PXCOPY (0x6...), drops valid 2 cycles, then sends PXPASTE (0x3...); A valid throughout -> no A accept between the two B cmds; A served the cycle after b_lock=0.
- draw_busy=1 for 5 cycles with a_valid=1 -> a_ready=0, cmd_rdy=0, stall_cnt=5. Then stall_rst=1 together with busy -> stall_cnt=0. 300 busy cycles -> stall_cnt=255.
- reset asserted the cycle after an accept -> cmd_rdy=0 next cycle, owner=00, stall_cnt=0.
- Random valid/lock/draw_busy for 10k cycles with a scoreboard: each port's accepted order is preserved, there are no duplicates or drops, and no accept occurs while draw_busy=1.
